// File: rtl/ddr3_avl_arbiter.sv
// ddr3_avl_arbiter: two-master round-robin arbiter onto one DDR3 Avalon port with read-tag tracking
module ddr3_avl_arbiter #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 128,
  parameter int MAX_RD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_read_req,
  input  logic              m0_write_req,
  input  logic              m0_burstbegin,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [2:0]        m0_size,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_rdata_valid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_read_req,
  input  logic              m1_write_req,
  input  logic              m1_burstbegin,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [2:0]        m1_size,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_rdata_valid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              avl_ready,
  output logic              avl_burstbegin,
  output logic              avl_read_req,
  output logic              avl_write_req,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [2:0]        avl_size,
  output logic [DATA_W-1:0] avl_wdata,
  input  logic              avl_rdata_valid,
  input  logic [DATA_W-1:0] avl_rdata,
  output logic              err_rdata
);
  localparam int PW = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
  typedef enum logic [1:0] {IDLE, CMD, WR_BURST} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, last_q, last_d, err_q, err_d;
  logic [2:0] wrem_q, wrem_d, rbeat_q, rbeat_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [3:0] tag_q [MAX_RD];
  logic [3:0] tag_d [MAX_RD];
  logic r0, r1, arb, active, full, empty, rd_acc, wr_acc, rv, pop;
  logic g_read, g_write, g_bb;
  logic [ADDR_W-1:0] g_addr;
  logic [2:0] g_size, wsize, hsize;
  logic [DATA_W-1:0] g_wdata;
  logic [3:0] head;
  // granted-master mux, arbitration and acceptance/return qualifiers
  always_comb begin
    g_read = grant_q ? m1_read_req : m0_read_req;
    g_write = grant_q ? m1_write_req : m0_write_req;
    g_bb = grant_q ? m1_burstbegin : m0_burstbegin;
    g_addr = grant_q ? m1_addr : m0_addr;
    g_size = grant_q ? m1_size : m0_size;
    g_wdata = grant_q ? m1_wdata : m0_wdata;
    r0 = m0_read_req | m0_write_req;
    r1 = m1_read_req | m1_write_req;
    arb = (r0 & r1) ? ~last_q : r1;
    active = state_q != IDLE;
    full = cnt_q == (PW+1)'(MAX_RD);
    empty = cnt_q == '0;
    rd_acc = (state_q == CMD) & g_read & ~full & avl_ready;
    wr_acc = active & g_write & ~g_read & avl_ready;
    wsize = (g_size == 3'd0) ? 3'd1 : g_size;
    head = tag_q[rp_q];
    hsize = (head[2:0] == 3'd0) ? 3'd1 : head[2:0];
    rv = avl_rdata_valid & ~empty;
    pop = rv & (rbeat_q + 3'd1 == hsize);
  end
  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = (r0 | r1) ? CMD : IDLE;
      CMD: state_d = rd_acc ? IDLE : wr_acc ? ((wsize <= 3'd1) ? IDLE : WR_BURST) : (!g_read && !g_write) ? IDLE : CMD;
      WR_BURST: state_d = (wr_acc && wrem_q == 3'd1) ? IDLE : WR_BURST;
      default: state_d = IDLE;
    endcase
  end
  // outputs: avl side mirrors the granted master only while a command is active
  always_comb begin
    avl_read_req = active & g_read & ~full;
    avl_write_req = active & g_write;
    avl_burstbegin = active & g_bb;
    avl_addr = active ? g_addr : '0;
    avl_size = active ? g_size : '0;
    avl_wdata = active ? g_wdata : '0;
    m0_ready = active & avl_ready & ~grant_q & ~(g_read & full);
    m1_ready = active & avl_ready & grant_q & ~(g_read & full);
    m0_rdata_valid = rv & ~head[3];
    m1_rdata_valid = rv & head[3];
    m0_rdata = avl_rdata;
    m1_rdata = avl_rdata;
    err_rdata = err_q;
  end
  // grant, write-beat countdown, read-tag FIFO and orphan-beat error
  always_comb begin
    grant_d = (state_q == IDLE && (r0 | r1)) ? arb : grant_q;
    last_d = (state_q == IDLE && (r0 | r1)) ? arb : last_q;
    wrem_d = !wr_acc ? wrem_q : (state_q == CMD) ? wsize - 3'd1 : wrem_q - 3'd1;
    tag_d = tag_q;
    if (rd_acc) tag_d[wp_q] = {grant_q, g_size};
    wp_d = wp_q + PW'(rd_acc);
    rp_d = rp_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(rd_acc) - (PW+1)'(pop);
    rbeat_d = !rv ? rbeat_q : pop ? 3'd0 : rbeat_q + 3'd1;
    err_d = err_q | (avl_rdata_valid & empty);
  end
  // state register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q <= 1'b1;
      wrem_q <= '0;
      rbeat_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      tag_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      wrem_q <= wrem_d;
      rbeat_q <= rbeat_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      tag_q <= tag_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// tb_ddr3_avl_arbiter: directed checks of arbitration, bursts, read tagging and reset
module tb_ddr3_avl_arbiter;
  logic clk = 0, reset;
  logic m0_read_req, m0_write_req, m0_burstbegin, m0_ready, m0_rdata_valid;
  logic m1_read_req, m1_write_req, m1_burstbegin, m1_ready, m1_rdata_valid;
  logic [25:0] m0_addr, m1_addr, avl_addr;
  logic [2:0] m0_size, m1_size, avl_size;
  logic [127:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, avl_wdata, avl_rdata;
  logic avl_ready, avl_burstbegin, avl_read_req, avl_write_req, avl_rdata_valid, err_rdata;
  int total = 0, bad = 0;

  ddr3_avl_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_read_req(m0_read_req), .m0_write_req(m0_write_req), .m0_burstbegin(m0_burstbegin),
    .m0_addr(m0_addr), .m0_size(m0_size), .m0_wdata(m0_wdata), .m0_ready(m0_ready),
    .m0_rdata_valid(m0_rdata_valid), .m0_rdata(m0_rdata),
    .m1_read_req(m1_read_req), .m1_write_req(m1_write_req), .m1_burstbegin(m1_burstbegin),
    .m1_addr(m1_addr), .m1_size(m1_size), .m1_wdata(m1_wdata), .m1_ready(m1_ready),
    .m1_rdata_valid(m1_rdata_valid), .m1_rdata(m1_rdata),
    .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin), .avl_read_req(avl_read_req),
    .avl_write_req(avl_write_req), .avl_addr(avl_addr), .avl_size(avl_size), .avl_wdata(avl_wdata),
    .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata), .err_rdata(err_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic clear;
    m0_read_req = 0; m0_write_req = 0; m0_burstbegin = 0; m0_addr = 0; m0_size = 0; m0_wdata = 0;
    m1_read_req = 0; m1_write_req = 0; m1_burstbegin = 0; m1_addr = 0; m1_size = 0; m1_wdata = 0;
    avl_ready = 0; avl_rdata_valid = 0; avl_rdata = 0;
  endtask

  task automatic do_reset;
    clear;
    reset = 1;
    cyc;
    cyc;
    reset = 0;
  endtask

  initial begin
    clear;
    reset = 1;
    avl_rdata = 'hABCD;
    m0_read_req = 1;
    avl_ready = 1;
    cyc;
    #1;
    chk("rst_rdreq", avl_read_req, 0);
    chk("rst_wrreq", avl_write_req, 0);
    chk("rst_m0rdy", m0_ready, 0);
    chk("rst_err", err_rdata, 0);
    chk("rst_rdata_pass", m1_rdata, 'hABCD);
    do_reset;
    // single read of two beats from m0
    m0_read_req = 1; m0_burstbegin = 1; m0_addr = 'h10; m0_size = 2; avl_ready = 1;
    #1 chk("rd_idle_req", avl_read_req, 0);
    cyc; #1;
    chk("rd_req", avl_read_req, 1);
    chk("rd_addr", avl_addr, 'h10);
    chk("rd_size", avl_size, 2);
    chk("rd_m0rdy", m0_ready, 1);
    chk("rd_m1rdy", m1_ready, 0);
    cyc;
    m0_read_req = 0; m0_burstbegin = 0;
    #1 chk("rd_back_idle", avl_read_req, 0);
    avl_rdata_valid = 1; avl_rdata = 'h11;
    #1;
    chk("rd_b0_v0", m0_rdata_valid, 1);
    chk("rd_b0_v1", m1_rdata_valid, 0);
    chk("rd_b0_data", m0_rdata, 'h11);
    cyc;
    avl_rdata = 'h22;
    #1 chk("rd_b1_v0", m0_rdata_valid, 1);
    cyc; #1;
    chk("orphan_v0", m0_rdata_valid, 0);
    chk("orphan_v1", m1_rdata_valid, 0);
    chk("orphan_err_pre", err_rdata, 0);
    cyc;
    avl_rdata_valid = 0;
    #1 chk("orphan_err", err_rdata, 1);
    cyc; cyc; #1;
    chk("err_sticky", err_rdata, 1);
    reset = 1;
    #1 chk("err_async_clr", err_rdata, 0);
    cyc;
    reset = 0;
    // round-robin with both masters requesting continuously
    m0_read_req = 1; m1_read_req = 1; m0_addr = 1; m1_addr = 2; m0_size = 1; m1_size = 1; avl_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cyc; #1;
      chk("rr_addr", avl_addr, (i % 2) ? 2 : 1);
      chk("rr_m1rdy", m1_ready, i % 2);
      chk("rr_m0rdy", m0_ready, (i % 2) ? 0 : 1);
      cyc; #1;
      chk("rr_idle", avl_read_req, 0);
    end
    do_reset;
    // tag FIFO full stalls the fifth read
    m0_read_req = 1; m0_size = 1; avl_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cyc; #1;
      chk("fill_rdy", m0_ready, 1);
      cyc;
    end
    cyc; #1;
    chk("full_rdy", m0_ready, 0);
    chk("full_req", avl_read_req, 0);
    cyc; #1;
    chk("full_hold", m0_ready, 0);
    avl_rdata_valid = 1;
    #1;
    chk("full_ret_v", m0_rdata_valid, 1);
    chk("full_ret_rdy", m0_ready, 0);
    cyc;
    avl_rdata_valid = 0;
    #1;
    chk("fifth_rdy", m0_ready, 1);
    chk("fifth_req", avl_read_req, 1);
    cyc;
    m0_read_req = 0;
    reset = 1;
    cyc;
    reset = 0;
    #1 chk("rst_out_err", err_rdata, 0);
    avl_rdata_valid = 1;
    #1 chk("rst_out_v", m0_rdata_valid, 0);
    cyc;
    avl_rdata_valid = 0;
    #1 chk("rst_out_orphan", err_rdata, 1);
    do_reset;
    // m1 write burst of 4 with backpressure, m0 read waits
    m1_write_req = 1; m1_burstbegin = 1; m1_size = 4; m1_wdata = 'hA0; m1_addr = 'h40; avl_ready = 1;
    cyc;
    m0_read_req = 1; m0_size = 1; m0_addr = 'h7;
    #1;
    chk("wr_b1_req", avl_write_req, 1);
    chk("wr_b1_data", avl_wdata, 'hA0);
    chk("wr_b1_bb", avl_burstbegin, 1);
    chk("wr_b1_m1rdy", m1_ready, 1);
    chk("wr_b1_m0rdy", m0_ready, 0);
    chk("wr_b1_rdreq", avl_read_req, 0);
    cyc;
    m1_burstbegin = 0; m1_wdata = 'hA1; avl_ready = 0;
    #1;
    chk("wr_stall_rdy", m1_ready, 0);
    chk("wr_stall_bb", avl_burstbegin, 0);
    for (int i = 0; i < 2; i++) begin
      cyc; #1;
      chk("wr_stall_rdy", m1_ready, 0);
      chk("wr_stall_data", avl_wdata, 'hA1);
    end
    cyc;
    avl_ready = 1;
    #1;
    chk("wr_b2_rdy", m1_ready, 1);
    chk("wr_b2_data", avl_wdata, 'hA1);
    cyc;
    m1_wdata = 'hA2;
    #1;
    chk("wr_b3_rdy", m1_ready, 1);
    chk("wr_b3_m0rdy", m0_ready, 0);
    cyc;
    m1_wdata = 'hA3;
    #1;
    chk("wr_b4_rdy", m1_ready, 1);
    chk("wr_b4_data", avl_wdata, 'hA3);
    cyc;
    m1_write_req = 0;
    #1;
    chk("wr_done_idle", avl_write_req, 0);
    chk("wr_done_m0rdy", m0_ready, 0);
    cyc; #1;
    chk("wr_then_rd", avl_read_req, 1);
    chk("wr_then_rdy", m0_ready, 1);
    chk("wr_then_addr", avl_addr, 'h7);
    do_reset;
    // reset in the middle of a write burst
    m0_write_req = 1; m0_burstbegin = 1; m0_size = 4; m0_addr = 'h20; avl_ready = 1;
    cyc; #1 chk("mb_b1", avl_write_req, 1);
    cyc; #1;
    chk("mb_b2", avl_write_req, 1);
    chk("mb_b2_bb", avl_burstbegin, 1);
    reset = 1;
    #1;
    chk("mb_rst_wr", avl_write_req, 0);
    chk("mb_rst_rdy", m0_ready, 0);
    chk("mb_rst_bb", avl_burstbegin, 0);
    chk("mb_rst_addr", avl_addr, 0);
    cyc;
    reset = 0;
    #1 chk("mb_rel_idle", avl_write_req, 0);
    cyc; #1;
    chk("mb_fresh_wr", avl_write_req, 1);
    chk("mb_fresh_rdy", m0_ready, 1);
    chk("mb_fresh_addr", avl_addr, 'h20);
    clear;
    cyc;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
